// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arbiter
// Purpose  : Shares one SPI flash port between NUM_REQ SPI masters. Grants
//            are round-robin, held until the owner drops its request, and
//            separated by CS_GAP clocks of chip-select high so the flash
//            never sees two owners' bits inside one command.
// Ports    : clk, reset (sync, active high)
//            req[N]      per-master request, held for the whole transfer
//            grant[N]    registered one-hot (or zero) grant
//            m_cs_b/m_sck/m_mosi[N]  per-master SPI outputs
//            m_miso      flash MISO broadcast to every master
//            spi_cs/spi_sck/spi_mosi/spi_miso  flash pins
//            busy        high while a grant is held or the CS gap runs
//            timeout_err 1-clk pulse on a forced revoke
// Options  : `define SPI_ARB_TIMEOUT_EN to revoke grants held for
//            TIMEOUT_CYCLES clocks; otherwise grants are held indefinitely
//            and timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CS_GAP         = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic [NUM_REQ-1:0] m_cs_b,
  input  logic [NUM_REQ-1:0] m_sck,
  input  logic [NUM_REQ-1:0] m_mosi,
  output logic               m_miso,
  output logic               spi_cs,
  output logic               spi_sck,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic               busy,
  output logic               timeout_err
);

  localparam int              OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [OW-1:0]   LAST_IDX = OW'(NUM_REQ - 1);
  localparam logic [7:0]      GAP_INIT = 8'(CS_GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] grant_nx;
  // last_owner doubles as the current owner index while a grant is held.
  logic [OW-1:0]      last_owner, last_owner_nx;
  logic [OW-1:0]      cand, pick;
  logic               found;
  logic [7:0]         gap_cnt, gap_cnt_nx;
  logic [NUM_REQ-1:0] eligible;
  logic               revoke;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);

  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nx;
  // A revoked master stays out of arbitration until it drops req once.
  logic [NUM_REQ-1:0] mask, mask_nx;
  logic               timeout_err_nx;

  assign eligible = req & ~mask;
  assign revoke   = (state == ST_GRANT) && (hold_cnt == HOLD_LAST);
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign eligible       = req;
  assign revoke         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Next-state and next-grant logic.
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_owner_nx = last_owner;
    gap_cnt_nx    = gap_cnt;
    found         = 1'b0;
    cand          = last_owner;
    pick          = last_owner;
`ifdef SPI_ARB_TIMEOUT_EN
    hold_cnt_nx    = hold_cnt;
    mask_nx        = mask & req;
    timeout_err_nx = 1'b0;
`endif

    // Rotating search starting one past the previous owner.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + OW'(1);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          last_owner_nx  = pick;
          state_nx       = ST_GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
          hold_cnt_nx    = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[last_owner] || revoke) begin
          grant_nx   = '0;
          gap_cnt_nx = GAP_INIT;
          state_nx   = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
`ifdef SPI_ARB_TIMEOUT_EN
          if (req[last_owner]) begin
            timeout_err_nx      = 1'b1;
            mask_nx[last_owner] = 1'b1;
          end
`endif
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else begin
          hold_cnt_nx = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nx = ST_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_owner <= LAST_IDX;
      gap_cnt    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      mask        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_owner <= last_owner_nx;
      gap_cnt    <= gap_cnt_nx;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_cnt    <= hold_cnt_nx;
      mask        <= mask_nx;
      timeout_err <= timeout_err_nx;
`endif
    end
  end

  // Flash pins follow the owner only while the registered grant is set;
  // otherwise the bus is parked deselected.
  assign busy     = (state != ST_IDLE);
  assign m_miso   = spi_miso;
  assign spi_cs   = (|grant) ? m_cs_b[last_owner] : 1'b1;
  assign spi_sck  = (|grant) & m_sck[last_owner];
  assign spi_mosi = (|grant) & m_mosi[last_owner];

endmodule
`default_nettype wire
